nibble_serial_adder_ctrl: RTL
=============================

// Module: nibble_serial_adder_ctrl
//
// PURPOSE
// - Sequences one external 4-bit ripple adder (74HC283-style: a/b nibbles, cin, sum nibble, cout)
//   to add two NIBBLES*4-bit operands, one nibble per clock cycle, least-significant nibble first.
// - Holds the operands, presents one nibble pair per cycle, chains the carry between cycles
//   and collects the result.
// - Sits between the register-level datapath and the shared adder instance.
//
// PARAMETERS
// - NIBBLES   default 4   Operand width in nibbles (W = 4*NIBBLES). Legal range 2..16.
//
// PORTS
// - clk        in   1     Rising-edge clock.
// - rst        in   1     Asynchronous reset, active-high.
// - start      in   1     Request an addition. Sampled only in IDLE or DONE.
// - op_a       in   W     Operand A. Captured on an accepted start.
// - op_b       in   W     Operand B. Captured on an accepted start.
// - op_cin     in   1     Carry-in to nibble 0. Captured on an accepted start.
// - add_a      out  4     Nibble of A driven to the adder.
// - add_b      out  4     Nibble of B driven to the adder.
// - add_cin    out  1     Carry driven to the adder.
// - add_s      in   4     Adder sum nibble. Combinational from add_a, add_b and add_cin.
// - add_cout   in   1     Adder carry out.
// - busy       out  1     High while a nibble is being processed (RUN state).
// - done       out  1     One-cycle pulse: sum and cout are valid.
// - sum        out  W     Result register. Holds until the next accepted start.
// - cout       out  1     Final carry out. Holds like sum.
//
// BEHAVIOUR
// - Reset: state=IDLE; idx, carry, operand regs, sum and cout cleared to 0.
//   busy=0, done=0, add_a=add_b=0, add_cin=0.
//   Reset mid-RUN aborts the operation. No done pulse is issued.
// - States:
//   - IDLE: start=1 -> capture op_a, op_b, op_cin; idx<=0; go to RUN. Otherwise stay.
//   - RUN: add_a=A[4*idx+:4], add_b=B[4*idx+:4], add_cin=carry (all combinational from registers).
//     - Each edge: sum[4*idx+:4]<=add_s; carry<=add_cout; idx<=idx+1.
//     - At idx==NIBBLES-1: cout<=add_cout, go to DONE.
//   - DONE: done=1 for exactly this cycle.
//     - start=1 -> capture the new operands and go to RUN (back-to-back; no dead cycle).
//     - Otherwise go to IDLE.
// - Outside RUN, add_a, add_b and add_cin are driven to 0.
// - Latency: start sampled at edge T. RUN occupies T+1..T+NIBBLES (busy=1).
//   done=1 in cycle T+NIBBLES+1. Throughput is one result per NIBBLES+1 cycles.
// - start while busy is ignored. It is not queued.
// - sum is updated nibble-by-nibble during RUN. It is only guaranteed valid while done=1 and
//   until the next accepted start.
// - Arithmetic: {cout,sum} = op_a + op_b + op_cin, modulo 2^(W+1). Wrap-around is legal:
//   the result truncates to W bits and the carry appears on cout.
// - idx width: clog2(NIBBLES). idx never exceeds NIBBLES-1.
//
// CONFIGURATION
// - Macro NSA_OVERFLOW_FLAG_EN:
//   - Defined: adds output port ovf (1 bit), registered in the DONE transition with
//     ovf = (A[W-1]==B[W-1]) && (sum[W-1]!=A[W-1]), i.e. two's-complement signed overflow.
//     ovf resets to 0 and holds like sum.
//   - Undefined: port ovf does not exist; no extra logic.
//
// TESTING (NIBBLES=4, behavioural 4-bit adder model attached to the add_* ports)
// 1. op_a=16'h1234, op_b=16'h4321, op_cin=0, start at T -> busy T+1..T+4; done at T+5;
//    sum=16'h5555, cout=0.
// 2. 16'hFFFF + 16'h0001, op_cin=0 -> sum=16'h0000, cout=1. The carry ripples through all 4 nibbles.
// 3. 16'hFFFF + 16'h0000, op_cin=1 -> sum=16'h0000, cout=1.
//    Also check add_cin=1 on the first RUN cycle.
// 4. start=1 held through RUN with changed op_a -> ignored; result matches the first operands.
//    start=1 during done -> second op begins next cycle; its done pulse follows 5 cycles later.
// 5. rst=1 asynchronously at T+2 of an add -> busy, done, sum and cout are 0 immediately.
//    No done pulse follows; the next start works normally.
// 6. With NSA_OVERFLOW_FLAG_EN: 16'h7FFF + 16'h0001 -> sum=16'h8000, ovf=1.
//    16'h8000 + 16'h8000 -> sum=0, cout=1, ovf=1. 16'h0001 + 16'h0001 -> ovf=0.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Purpose: bus between the serial-add controller and one shared 4-bit ripple adder.
// Signals:
//   add_a, add_b  nibble operands presented to the adder
//   add_cin       carry presented to the adder
//   add_s         adder sum nibble (combinational from add_a/add_b/add_cin)
//   add_cout      adder carry out
// Modports: master = controller side, slave = adder side.
interface nibble_serial_adder_ctrl_if;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic       add_cin;
  logic [3:0] add_s;
  logic       add_cout;

  modport master (
    output add_a,
    output add_b,
    output add_cin,
    input  add_s,
    input  add_cout
  );

  modport slave (
    input  add_a,
    input  add_b,
    input  add_cin,
    output add_s,
    output add_cout
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Purpose: sequences one external 4-bit ripple adder to add two NIBBLES*4-bit
// operands, one nibble per cycle, least-significant nibble first.
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   start              request an addition (sampled in IDLE or DONE only)
//   op_a, op_b, op_cin operands and carry-in, captured on an accepted start
//   bus (master)       add_a/add_b/add_cin to the adder, add_s/add_cout back
//   busy               high during the NIBBLES RUN cycles
//   done               one-cycle pulse when sum/cout are valid
//   sum, cout          result, held until the next accepted start
//   ovf                signed overflow flag, only when NSA_OVERFLOW_FLAG_EN is defined
// Configuration macro: NSA_OVERFLOW_FLAG_EN.
module nibble_serial_adder_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [4*NIBBLES-1:0]        op_a,
  input  logic [4*NIBBLES-1:0]        op_b,
  input  logic                        op_cin,
  nibble_serial_adder_ctrl_if.master  bus,
  output logic                        busy,
  output logic                        done,
  output logic [4*NIBBLES-1:0]        sum,
  output logic                        cout
`ifdef NSA_OVERFLOW_FLAG_EN
  ,
  output logic                        ovf
`endif
);

  localparam int unsigned W     = 4 * NIBBLES;
  localparam int unsigned IDX_W = $clog2(NIBBLES);

  if (NIBBLES < 2 || NIBBLES > 16) begin : g_bad_nibbles
    $error("nibble_serial_adder_ctrl: NIBBLES must be in 2..16");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             last;

  assign last    = (idx == IDX_W'(NIBBLES - 1));
  assign idx_nxt = idx + IDX_W'(1);

  // Adder drive is registered so it already points at the nibble of the
  // current idx; add_cin doubles as the inter-nibble carry register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum         <= '0;
      cout        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bus.add_a   <= 4'h0;
      bus.add_b   <= 4'h0;
      bus.add_cin <= 1'b0;
`ifdef NSA_OVERFLOW_FLAG_EN
      ovf         <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q         <= op_a;
            b_q         <= op_b;
            idx         <= '0;
            busy        <= 1'b1;
            bus.add_a   <= op_a[3:0];
            bus.add_b   <= op_b[3:0];
            bus.add_cin <= op_cin;
            state       <= RUN;
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          sum[4*idx +: 4] <= bus.add_s;
          if (last) begin
            cout        <= bus.add_cout;
            idx         <= '0;
            busy        <= 1'b0;
            done        <= 1'b1;
            bus.add_a   <= 4'h0;
            bus.add_b   <= 4'h0;
            bus.add_cin <= 1'b0;
`ifdef NSA_OVERFLOW_FLAG_EN
            // Top sum bit is the one being written on this edge.
            ovf         <= (a_q[W-1] == b_q[W-1]) && (bus.add_s[3] != a_q[W-1]);
`endif
            state       <= DONE;
          end else begin
            idx         <= idx_nxt;
            bus.add_a   <= a_q[4*idx_nxt +: 4];
            bus.add_b   <= b_q[4*idx_nxt +: 4];
            bus.add_cin <= bus.add_cout;
          end
        end

        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          bus.add_a   <= 4'h0;
          bus.add_b   <= 4'h0;
          bus.add_cin <= 1'b0;
        end
      endcase
    end
  end

endmodule
